// File: rtl/conv_pkg.sv
// Shared types and default geometry for the conv frame controller slice.
package conv_pkg;

  localparam int unsigned IMG_W        = 28;
  localparam int unsigned IMG_H        = 28;
  localparam int unsigned K            = 5;
  localparam int unsigned CONV_FILTERS = 8;
  localparam int unsigned OUT_W        = IMG_W - K + 1;
  localparam int unsigned OUT_H        = IMG_H - K + 1;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    STREAM,
    DRAIN,
    DONE
  } frame_state_t;

endpackage

// File: rtl/conv_rc_counter.sv
// Row/column position counter for conv output tags; column wraps into row.
module conv_rc_counter
  import conv_pkg::*;
#(
  parameter int unsigned ROWS = 24,
  parameter int unsigned COLS = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr,
  output logic [$clog2(ROWS)-1:0]   row,
  output logic [$clog2(COLS)-1:0]   col,
  output logic                      last_c
);

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);

  assign last_c = (row == ROW_W'(ROWS - 1)) && (col == COL_W'(COLS - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == COL_W'(COLS - 1)) begin
        col <= '0;
        row <= (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer: meters FWFT pops into the conv engine, counts and tags
// conv outputs, and reports frame completion and protocol errors.
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W   = conv_pkg::IMG_W,
  parameter int unsigned IMG_H   = conv_pkg::IMG_H,
  parameter int unsigned K       = conv_pkg::K,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            fifo_valid,
  output logic                            fifo_rd_en,
  output logic                            conv_feat_valid,
  input  logic                            conv_buf_full,
  input  logic                            conv_out_valid,
  output logic                            conv_flush,
  output logic [$clog2(IMG_H-K+1)-1:0]    out_row,
  output logic [$clog2(IMG_W-K+1)-1:0]    out_col,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            err_overrun,
  output logic                            err_timeout
);

  localparam int unsigned OUT_COLS  = IMG_W - K + 1;
  localparam int unsigned OUT_ROWS  = IMG_H - K + 1;
  localparam int unsigned PIX_TOTAL = IMG_W * IMG_H;
  localparam int unsigned OUT_TOTAL = OUT_COLS * OUT_ROWS;
  localparam int unsigned IN_W      = $clog2(PIX_TOTAL + 1);
  localparam int unsigned OCNT_W    = $clog2(OUT_TOTAL + 1);
  localparam int unsigned IDLE_W    = $clog2(TIMEOUT + 1);

  frame_state_t state, next_state;
  logic [IN_W-1:0]   in_cnt;
  logic [OCNT_W-1:0] out_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  logic in_full, out_full, active, feeding;
  logic start_ok, abort_hit, count_out, overrun_hit, timeout_hit, out_last_c;

  assign in_full     = (in_cnt == IN_W'(PIX_TOTAL));
  assign out_full    = (out_cnt == OCNT_W'(OUT_TOTAL));
  assign feeding     = (state == FILL) || (state == STREAM);
  assign active      = feeding || (state == DRAIN);
  assign start_ok    = (state == IDLE) && start && !abort;
  assign abort_hit   = (state != IDLE) && abort;
  assign count_out   = active && conv_out_valid && !out_full;
  assign overrun_hit = conv_out_valid && (!active || out_full);
  assign timeout_hit = (state == DRAIN) && (idle_cnt == IDLE_W'(TIMEOUT));

  // Pop gate is combinational so the FWFT head moves in the cycle it is consumed.
  assign fifo_rd_en      = feeding && fifo_valid && !in_full && !abort;
  assign conv_feat_valid = fifo_rd_en;

  conv_rc_counter #(
    .ROWS (OUT_ROWS),
    .COLS (OUT_COLS)
  ) u_rc (
    .clk    (clk),
    .rst    (rst),
    .en     (count_out),
    .clr    (start_ok || abort_hit),
    .row    (out_row),
    .col    (out_col),
    .last_c (out_last_c)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (start_ok) next_state = FILL;
      FILL: begin
        if (abort)              next_state = IDLE;
        else if (in_full)       next_state = DRAIN;
        else if (conv_buf_full) next_state = STREAM;
      end
      STREAM: begin
        if (abort)        next_state = IDLE;
        else if (in_full) next_state = DRAIN;
      end
      // Leave as soon as the final tagged output is accepted.
      DRAIN: begin
        if (abort) next_state = IDLE;
        else if (out_full || (count_out && out_last_c) || timeout_hit) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      idle_cnt    <= '0;
      conv_flush  <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state      <= next_state;
      conv_flush <= start_ok || abort_hit;
      busy       <= (next_state != IDLE);
      frame_done <= (next_state == DONE);

      if (start_ok || abort_hit) in_cnt <= '0;
      else if (fifo_rd_en)       in_cnt <= in_cnt + IN_W'(1);

      if (start_ok || abort_hit) out_cnt <= '0;
      else if (count_out)        out_cnt <= out_cnt + OCNT_W'(1);

      if (abort_hit || (state != DRAIN) || conv_out_valid) idle_cnt <= '0;
      else if (!timeout_hit)                               idle_cnt <= idle_cnt + IDLE_W'(1);

      err_overrun <= (err_overrun && !start_ok) || overrun_hit;
      err_timeout <= (err_timeout && !start_ok) || (timeout_hit && !abort);
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl: IDLE control vector table plus
// randomized whole-frame runs against a pixel/output bookkeeping model.
module tb_conv_frame_ctrl;

  localparam int IMG_W   = 28;
  localparam int IMG_H   = 28;
  localparam int K       = 5;
  localparam int TIMEOUT = 1024;
  localparam int OW      = IMG_W - K + 1;
  localparam int OH      = IMG_H - K + 1;
  localparam int PIX     = IMG_W * IMG_H;
  localparam int OUTS    = OW * OH;
  localparam int PRIME   = (K - 1) * IMG_W + K;
  localparam int BUDGET  = 8000;

  logic clk, rst, start, abort, fifo_valid, conv_buf_full, conv_out_valid;
  logic fifo_rd_en, conv_feat_valid, conv_flush, busy, frame_done, err_overrun, err_timeout;
  logic [$clog2(OH)-1:0] out_row;
  logic [$clog2(OW)-1:0] out_col;

  int n_checks = 0;
  int n_fail   = 0;

  conv_frame_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .fifo_valid(fifo_valid), .fifo_rd_en(fifo_rd_en), .conv_feat_valid(conv_feat_valid),
    .conv_buf_full(conv_buf_full), .conv_out_valid(conv_out_valid), .conv_flush(conv_flush),
    .out_row(out_row), .out_col(out_col), .busy(busy), .frame_done(frame_done),
    .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; fifo_valid = 0; conv_buf_full = 0; conv_out_valid = 0;
  endtask

  typedef struct {
    bit start, abort, fv, cov;
    bit exp_rd, exp_busy, exp_flush, exp_ovr;
  } vec_t;

  // One complete frame; abort_at/stray_at < 0 disables those events.
  task automatic run_frame(input string nm, input int pct, input int n_outs,
                           input int abort_at, input int stray_at);
    int pops = 0, outs = 0, cyc = 0, done_cnt = 0, done_cyc = -1, last_evt = 0;
    int bad_pop = 0, fv_mis = 0, tag_errs = 0, extra_pops = 0;
    bit aborted = 0, stray_done = 0, stray_pending = 0, finished = 0;

    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    #1;
    chk({nm, "_flush_after_start"}, conv_flush, 1);
    chk({nm, "_busy_after_start"}, busy, 1);
    chk({nm, "_errs_cleared"}, {err_overrun, err_timeout}, 0);

    while (!finished && cyc < BUDGET) begin
      fifo_valid     = ($urandom_range(99) < pct);
      conv_buf_full  = (pops >= PRIME);
      conv_out_valid = !aborted && conv_buf_full && outs < n_outs && ($urandom_range(99) < 40);
      abort          = (abort_at >= 0 && pops == abort_at && !aborted);
      if (abort) fifo_valid = 1;
      start          = (stray_at >= 0 && pops == stray_at && !stray_done);
      #1;
      if (fifo_rd_en && !fifo_valid) bad_pop++;
      if (conv_feat_valid != fifo_rd_en) fv_mis++;
      if (conv_out_valid && (int'(out_row) != outs / OW || int'(out_col) != outs % OW)) tag_errs++;
      if (stray_pending) begin
        chk({nm, "_stray_start_no_flush"}, conv_flush, 0);
        chk({nm, "_stray_start_busy"}, busy, 1);
        stray_pending = 0;
      end
      if (done_cyc >= 0) begin
        chk({nm, "_busy_after_done"}, busy, 0);
        chk({nm, "_done_one_cycle"}, frame_done, 0);
        finished = 1;
      end else if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (start) begin stray_done = 1; stray_pending = 1; end
      if (abort) chk({nm, "_rd_en_on_abort"}, fifo_rd_en, 0);
      if (fifo_rd_en) begin pops++; last_evt = cyc; end
      if (conv_out_valid) begin outs++; last_evt = cyc; end
      @(negedge clk); cyc++;
      if (abort) begin
        aborted = 1;
        idle_inputs();
        #1;
        chk({nm, "_flush_after_abort"}, conv_flush, 1);
        chk({nm, "_idle_after_abort"}, busy, 0);
        @(negedge clk); #1;
        chk({nm, "_flush_one_cycle"}, conv_flush, 0);
        chk({nm, "_no_done_on_abort"}, done_cnt + frame_done, 0);
        finished = 1;
      end
    end
    if (!finished) chk({nm, "_frame_budget"}, 0, 1);
    idle_inputs();
    if (aborted) return;

    // Frame boundary: the next pixel must stay in the FWFT.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); fifo_valid = 1; #1;
      if (fifo_rd_en) extra_pops++;
    end
    fifo_valid = 0;

    chk({nm, "_pops"}, pops, PIX);
    chk({nm, "_pops_past_frame"}, extra_pops, 0);
    chk({nm, "_pop_without_valid"}, bad_pop, 0);
    chk({nm, "_feat_valid_tie"}, fv_mis, 0);
    chk({nm, "_tag_errors"}, tag_errs, 0);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_err_overrun"}, err_overrun, 0);
    chk({nm, "_err_timeout"}, err_timeout, (n_outs < OUTS) ? 1 : 0);
    if (n_outs < OUTS) chk_range({nm, "_timeout_latency"}, done_cyc - last_evt, TIMEOUT, TIMEOUT + 8);
    else               chk_range({nm, "_done_latency"}, done_cyc - last_evt, 1, 8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{0, 0, 1, 0,  0, 0, 0, 0};
    vecs[1] = '{1, 1, 1, 0,  0, 0, 0, 0};
    vecs[2] = '{0, 0, 0, 1,  0, 0, 0, 1};
    vecs[3] = '{1, 0, 1, 0,  0, 1, 1, 0};
    vecs[4] = '{0, 1, 1, 0,  0, 0, 0, 0};
    vecs[5] = '{0, 0, 0, 1,  0, 0, 0, 1};
    vecs[6] = '{1, 0, 0, 0,  0, 1, 1, 0};

    idle_inputs();
    rst = 1;
    fifo_valid = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("reset_rd_en", fifo_rd_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", frame_done, 0);
    chk("reset_flush", conv_flush, 0);
    chk("reset_errs", {err_overrun, err_timeout}, 0);
    chk("reset_tags", {out_row, out_col}, 0);
    fifo_valid = 0;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = vecs[i].start; abort = vecs[i].abort;
      fifo_valid = vecs[i].fv; conv_out_valid = vecs[i].cov;
      #1;
      chk($sformatf("vec%0d_rd_en", i), fifo_rd_en, vecs[i].exp_rd);
      @(negedge clk);
      idle_inputs();
      #1;
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      chk($sformatf("vec%0d_flush", i), conv_flush, vecs[i].exp_flush);
      chk($sformatf("vec%0d_overrun", i), err_overrun, vecs[i].exp_ovr);
      if (busy) begin
        abort = 1;
        @(negedge clk); abort = 0;
        @(negedge clk);
      end
    end

    run_frame("nominal", 100, OUTS, -1, -1);
    run_frame("random50", 50, OUTS, -1, -1);
    run_frame("abort", 70, OUTS, 300, -1);
    run_frame("after_abort", 100, OUTS, -1, -1);
    run_frame("timeout", 80, OUTS - 1, -1, -1);
    repeat (5) @(negedge clk);
    #1;
    chk("timeout_sticky", err_timeout, 1);
    run_frame("stray_start", 60, OUTS, -1, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
